// File: rtl/cpu_run_monitor.sv
// Run monitor beside the caddr CPU: decode-cycle counter, limit/breakpoint halt, PC trace.
// Optional trace buffer is built when CPU_RUN_MONITOR_TRACE_EN is defined.
module cpu_run_monitor #(
  parameter int PC_W  = 14,
  parameter int CNT_W = 32,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      state,
  input  logic            run,
  input  logic            step,
  input  logic [PC_W-1:0] lpc,
  input  logic [2:0]      reg_addr,
  input  logic            reg_rd,
  input  logic            reg_wr,
  input  logic [15:0]     reg_wdata,
  output logic [15:0]     reg_rdata,
  output logic            halt_req,
  output logic [1:0]      halt_reason
);

  localparam int HI_W  = CNT_W - 16;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_BKPT   = 3'd2;
  localparam logic [2:0] A_LIM_LO = 3'd3;
  localparam logic [2:0] A_LIM_HI = 3'd4;
  localparam logic [2:0] A_CYC_LO = 3'd5;
  localparam logic [2:0] A_CYC_HI = 3'd6;
  localparam logic [2:0] A_TRACE  = 3'd7;

  // Assertion is immediate; release reaches the logic two edges later.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [2:0]       ctrl;
  logic [PC_W-1:0]  bkpt;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt;
  logic [HI_W-1:0]  hold;

  logic counted, inc, sat, clear, status_wr, limit_hit, bkpt_hit, rd_trace;
  logic [CNT_W-1:0] cnt_post;
  logic [15:0]      rd_mux;
  logic [15:0]      trace_data;
  logic [7:0]       trace_cnt8;

  assign counted   = (run | step) && (state == 6'b000001);
  assign inc       = counted && ctrl[0] && !halt_req;
  assign sat       = &cnt;
  assign cnt_post  = sat ? cnt : cnt + CNT_W'(1);
  assign clear     = reg_wr && (reg_addr == A_CTRL) && reg_wdata[3];
  assign status_wr = reg_wr && (reg_addr == A_STATUS);
  assign limit_hit = inc && ctrl[2] && (limit != '0) && (cnt_post == limit);
  assign bkpt_hit  = counted && ctrl[1] && (lpc == bkpt);
  assign rd_trace  = reg_rd && (reg_addr == A_TRACE);
  assign halt_req  = |halt_reason;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= '0;
      bkpt        <= '0;
      limit       <= '0;
      cnt         <= '0;
      hold        <= '0;
      halt_reason <= '0;
      reg_rdata   <= '0;
    end else begin
      if (reg_rd) reg_rdata <= rd_mux;
      if (reg_wr) begin
        case (reg_addr)
          A_CTRL:   ctrl <= reg_wdata[2:0];
          A_BKPT:   bkpt <= reg_wdata[PC_W-1:0];
          A_LIM_LO: limit[15:0] <= reg_wdata;
          A_LIM_HI: limit[CNT_W-1:16] <= reg_wdata[HI_W-1:0];
          default:  ;
        endcase
      end
      // A new hit overrides a same-cycle STATUS write; CLEAR overrides everything.
      if (clear) begin
        cnt         <= '0;
        hold        <= '0;
        halt_reason <= '0;
      end else begin
        if (inc) cnt <= cnt_post;
        if (reg_rd && (reg_addr == A_CYC_LO)) hold <= cnt[CNT_W-1:16];
        halt_reason <= (status_wr ? 2'b00 : halt_reason) | {bkpt_hit, limit_hit};
      end
    end
  end

`ifdef CPU_RUN_MONITOR_TRACE_EN
  logic [PC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, wr_ptr;
  logic [PTR_W:0]   tcount;
  logic [8:0]       tc9;
  logic             push, pop, full;

  assign full   = (tcount == (PTR_W+1)'(DEPTH));
  assign push   = counted && !halt_req;
  assign pop    = rd_trace && (tcount != '0);
  // With count == DEPTH the low bits wrap to head, i.e. the oldest slot.
  assign wr_ptr = head + tcount[PTR_W-1:0];
  assign tc9    = 9'(tcount);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lpc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tcount <= '0;
    end else if (clear) begin
      head   <= '0;
      tcount <= '0;
    end else begin
      if (pop || (push && full)) head <= head + PTR_W'(1);
      if (push && !pop && !full)  tcount <= tcount + (PTR_W+1)'(1);
      else if (pop && !push)      tcount <= tcount - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    trace_data = 16'hFFFF;
    if (tcount != '0) begin
      trace_data = '0;
      trace_data[PC_W-1:0] = mem[head];
    end
    trace_cnt8 = tc9[8] ? 8'hFF : tc9[7:0];
  end
`else
  assign trace_data = 16'hFFFF;
  assign trace_cnt8 = 8'h00;
`endif

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_CTRL:   rd_mux[2:0] = ctrl;
      A_STATUS: rd_mux = {trace_cnt8, 5'b0, halt_req, halt_reason};
      A_BKPT:   rd_mux[PC_W-1:0] = bkpt;
      A_LIM_LO: rd_mux = limit[15:0];
      A_LIM_HI: rd_mux[HI_W-1:0] = limit[CNT_W-1:16];
      A_CYC_LO: rd_mux = cnt[15:0];
      A_CYC_HI: rd_mux[HI_W-1:0] = hold;
      A_TRACE:  rd_mux = trace_data;
      default:  rd_mux = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor; trace expectations follow CPU_RUN_MONITOR_TRACE_EN.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  state = 6'b000010;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [13:0] lpc = '0;
  logic [2:0]  reg_addr = '0;
  logic        reg_rd = 1'b0;
  logic        reg_wr = 1'b0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic        halt_req;
  logic [1:0]  halt_reason;

  int tests = 0;
  int fails = 0;
  logic [15:0] d;

`ifdef CPU_RUN_MONITOR_TRACE_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  cpu_run_monitor dut (
    .clk(clk), .reset_n(reset_n), .state(state), .run(run), .step(step), .lpc(lpc),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .halt_req(halt_req), .halt_reason(halt_reason)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] v);
    reg_addr = a; reg_wdata = v; reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    reg_addr = a; reg_rd = 1'b1;
    @(posedge clk); #1;
    reg_rd = 1'b0;
    v = reg_rdata;
  endtask

  task automatic decode(input logic [13:0] pc, input logic use_step);
    state = 6'b000001; lpc = pc; run = !use_step; step = use_step;
    @(posedge clk); #1;
    state = 6'b000010; run = 1'b0; step = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", reg_rdata, 16'h0000);
    check("rst_halt", {15'b0, halt_req}, 16'h0000);
    check("rst_reason", {14'b0, halt_reason}, 16'h0000);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(3'd0, d); check("rst_ctrl", d, 16'h0000);
    rd(3'd5, d); check("rst_cyclo", d, 16'h0000);
    rd(3'd7, d); check("rst_trace_empty", d, 16'hFFFF);

    // Cycle limit
    wr(3'd3, 16'd5); wr(3'd4, 16'd0); wr(3'd0, 16'h0005);
    state = 6'b000100; run = 1'b1; @(posedge clk); #1; run = 1'b0; state = 6'b000010;
    for (int i = 0; i < 8; i++) begin
      decode(14'd100 + 14'(i), 1'b0);
      check($sformatf("lim_halt_%0d", i), {15'b0, halt_req}, (i >= 4) ? 16'h1 : 16'h0);
    end
    check("lim_reason", {14'b0, halt_reason}, 16'h0001);
    rd(3'd5, d); check("lim_cyclo", d, 16'd5);
    rd(3'd1, d); check("lim_status", d, TE ? 16'h0505 : 16'h0005);
    wr(3'd0, 16'h000D);
    check("clr_halt", {15'b0, halt_req}, 16'h0000);
    rd(3'd5, d); check("clr_cyclo", d, 16'd0);
    rd(3'd0, d); check("clr_ctrl_kept", d, 16'h0005);
    rd(3'd1, d); check("clr_status", d, 16'h0000);

    // Breakpoint
    wr(3'd0, 16'h0008); wr(3'd2, 16'o40); wr(3'd0, 16'h0003);
    decode(14'o36, 1'b1); decode(14'o37, 1'b1);
    check("bk_nohalt", {15'b0, halt_req}, 16'h0000);
    decode(14'o40, 1'b1);
    check("bk_halt", {15'b0, halt_req}, 16'h0001);
    check("bk_reason", {14'b0, halt_reason}, 16'h0002);
    decode(14'o41, 1'b0);
    rd(3'd5, d); check("bk_cyclo_frozen", d, 16'd3);
    rd(3'd2, d); check("bk_readback", d, 16'o40);
    rd(3'd7, d); check("bk_pop0", d, TE ? 16'o36 : 16'hFFFF);
    rd(3'd7, d); check("bk_pop1", d, TE ? 16'o37 : 16'hFFFF);
    rd(3'd7, d); check("bk_pop2", d, TE ? 16'o40 : 16'hFFFF);
    rd(3'd7, d); check("bk_pop_empty", d, 16'hFFFF);

    // Trace wrap
    wr(3'd0, 16'h0009);
    for (int i = 1; i <= 20; i++) decode(14'(i), 1'b0);
    rd(3'd1, d); check("wrap_status", d, TE ? 16'h1000 : 16'h0000);
    rd(3'd5, d); check("wrap_cyclo", d, 16'd20);
    for (int i = 5; i <= 20; i++) begin
      rd(3'd7, d); check($sformatf("wrap_pop_%0d", i), d, TE ? 16'(i) : 16'hFFFF);
    end
    rd(3'd7, d); check("wrap_pop_empty", d, 16'hFFFF);

    // Simultaneous limit and breakpoint
    wr(3'd0, 16'h0008); wr(3'd3, 16'd3); wr(3'd2, 16'h0203); wr(3'd0, 16'h0007);
    decode(14'h201, 1'b0); decode(14'h202, 1'b0); decode(14'h203, 1'b0);
    check("sim_reason", {14'b0, halt_reason}, 16'h0003);
    rd(3'd1, d); check("sim_status", d, TE ? 16'h0307 : 16'h0007);
    wr(3'd1, 16'h0000);
    check("sim_cleared", {14'b0, halt_reason}, 16'h0000);
    decode(14'h300, 1'b0);
    rd(3'd5, d); check("sim_resume", d, 16'd4);
    // STATUS write racing a breakpoint hit
    wr(3'd2, 16'h0301);
    state = 6'b000001; lpc = 14'h301; run = 1'b1;
    reg_addr = 3'd1; reg_wdata = 16'h0; reg_wr = 1'b1;
    @(posedge clk); #1;
    state = 6'b000010; run = 1'b0; reg_wr = 1'b0;
    check("race_hit_wins", {14'b0, halt_reason}, 16'h0002);
    // Read and write of CTRL in one cycle
    reg_addr = 3'd0; reg_wdata = 16'h0009; reg_rd = 1'b1; reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_rd = 1'b0; reg_wr = 1'b0;
    check("rdwr_prewrite", reg_rdata, 16'h0007);
    check("rdwr_clear_halt", {15'b0, halt_req}, 16'h0000);
    rd(3'd0, d); check("rdwr_ctrl_new", d, 16'h0001);

    // Snapshot
    wr(3'd4, 16'hABCD);
    rd(3'd4, d); check("limhi_rw", d, 16'hABCD);
    wr(3'd4, 16'h0000); wr(3'd3, 16'h0000);
    state = 6'b000001; run = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    state = 6'b000010; run = 1'b0;
    rd(3'd5, d); check("snap_lo", d, 16'h0004);
    decode(14'h1, 1'b0); decode(14'h2, 1'b0); decode(14'h3, 1'b0);
    rd(3'd6, d); check("snap_hi", d, 16'h0001);
    rd(3'd5, d); check("snap_lo_after", d, 16'h0007);

    // Async reset mid-run
    wr(3'd2, 16'h0055); wr(3'd0, 16'h0003);
    decode(14'h055, 1'b0);
    check("ar_pre_halt", {15'b0, halt_req}, 16'h0001);
    rd(3'd0, d); check("ar_pre_ctrl", d, 16'h0003);
    state = 6'b000001; run = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("ar_halt", {15'b0, halt_req}, 16'h0000);
    check("ar_rdata", reg_rdata, 16'h0000);
    check("ar_reason", {14'b0, halt_reason}, 16'h0000);
    state = 6'b000010; run = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(3'd0, d); check("ar_ctrl", d, 16'h0000);
    rd(3'd5, d); check("ar_cyclo", d, 16'h0000);
    rd(3'd1, d); check("ar_status", d, 16'h0000);
    rd(3'd2, d); check("ar_bkpt", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
